// File: rtl/fhe_alu_pkg.sv
// Shared FHE ALU definitions: Benes geometry, per-entry routing config type and
// the sequencer state encoding.
package fhe_alu_pkg;

    localparam int STAGE_NUM     = 5;
    localparam int SWITCH_NUM    = 4;
    localparam int CFG_DEPTH_DEF = 16;
    localparam int CFG_AW        = $clog2(CFG_DEPTH_DEF);

    typedef struct packed {
        logic [STAGE_NUM-1:0][SWITCH_NUM-1:0] module_sel;
        logic [STAGE_NUM-1:0][SWITCH_NUM-1:0] slot_sel;
    } benes_cfg_t;

    localparam int CFG_W = $bits(benes_cfg_t);

    typedef enum logic [1:0] {
        SCHED_IDLE  = 2'd0,
        SCHED_FETCH = 2'd1,
        SCHED_HOLD  = 2'd2
    } sched_state_t;

    // Even parity: the stored bit makes data^bit reduce to zero.
    function automatic logic cfg_parity(input benes_cfg_t c);
        return ^c;
    endfunction

endpackage

// File: rtl/benes_cfg_ram.sv
// Simple dual-port config RAM, 1-cycle synchronous read, read-before-write.
// Optional parity storage/check when BENES_CFG_PARITY_EN is defined.
module benes_cfg_ram
    import fhe_alu_pkg::*;
#(
    parameter  int DEPTH = CFG_DEPTH_DEF,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  benes_cfg_t    i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output benes_cfg_t    o_rdata
`ifdef BENES_CFG_PARITY_EN
    ,
    output logic          o_par_err
`endif
);

    benes_cfg_t mem [DEPTH];

    // Read data register doubles as the hold register for the selects.
    always_ff @(posedge clk) begin
        if (i_we) mem[i_waddr] <= i_wdata;
        if (i_re) o_rdata <= mem[i_raddr];
    end

`ifdef BENES_CFG_PARITY_EN
    logic par_mem [DEPTH];
    logic rd_par;

    always_ff @(posedge clk) begin
        if (i_we) par_mem[i_waddr] <= cfg_parity(i_wdata);
        if (i_re) rd_par <= par_mem[i_raddr];
    end

    assign o_par_err = cfg_parity(o_rdata) ^ rd_par;
`endif

endmodule

// File: rtl/benes_route_sched.sv
// Benes interconnect configuration sequencer: plays runs of stored routing
// configs onto the select inputs. Optional parity: BENES_CFG_PARITY_EN.
module benes_route_sched
    import fhe_alu_pkg::*;
#(
    parameter  int CFG_DEPTH = CFG_DEPTH_DEF,
    parameter  int HOLD_W    = 8,
    localparam int AW        = $clog2(CFG_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_cfg_we,
    input  logic [AW-1:0]         i_cfg_waddr,
    input  benes_cfg_t            i_cfg_wdata,
    input  logic                  i_start,
    input  logic [AW-1:0]         i_base,
    input  logic [AW:0]           i_cnt,
    input  logic [HOLD_W-1:0]     i_hold,
    input  logic                  i_abort,
    output logic [SWITCH_NUM-1:0] o_module_select [0:STAGE_NUM-1],
    output logic [SWITCH_NUM-1:0] o_slot_select   [0:STAGE_NUM-1],
    output logic                  o_cfg_valid,
    output logic                  o_cfg_strobe,
    output logic [AW-1:0]         o_cfg_idx,
    output logic                  o_busy,
    output logic                  o_done
`ifdef BENES_CFG_PARITY_EN
    ,
    output logic                  o_parity_err
`endif
);

    localparam logic [AW-1:0]     IDX_ONE  = 1;
    localparam logic [AW:0]       CNT_ONE  = 1;
    localparam logic [HOLD_W-1:0] HOLD_ONE = 1;

    sched_state_t      state_q, state_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic [AW:0]       left_q, left_d;
    logic [HOLD_W-1:0] h_q, h_d;
    logic [HOLD_W-1:0] hcnt_q, hcnt_d;
    logic              rd_en, done_d, abort_run;
    logic              strobe_q, done_q, sel_live_q;
    logic [AW-1:0]     cfg_idx_q;
    benes_cfg_t        cfg_rd;

`ifdef BENES_CFG_PARITY_EN
    logic ram_par_err, par_abort, parity_err_q;
    // Each read result is checked in the cycle it lands on the selects.
    assign par_abort    = strobe_q & ram_par_err;
    assign o_parity_err = parity_err_q;
`else
    logic par_abort;
    assign par_abort = 1'b0;
`endif

    assign abort_run = i_abort | par_abort;

    benes_cfg_ram #(.DEPTH(CFG_DEPTH)) u_ram (
        .clk       (clk),
        .i_we      (i_cfg_we),
        .i_waddr   (i_cfg_waddr),
        .i_wdata   (i_cfg_wdata),
        .i_re      (rd_en),
        .i_raddr   (idx_q),
        .o_rdata   (cfg_rd)
`ifdef BENES_CFG_PARITY_EN
        ,
        .o_par_err (ram_par_err)
`endif
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        left_d  = left_q;
        h_d     = h_q;
        hcnt_d  = hcnt_q;
        rd_en   = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            SCHED_IDLE: begin
                if (i_start && !i_abort && (i_cnt != '0)) begin
                    state_d = SCHED_FETCH;
                    idx_d   = i_base;
                    left_d  = i_cnt;
                    h_d     = (i_hold == '0) ? HOLD_ONE : i_hold;
                end
            end
            SCHED_FETCH: begin
                if (abort_run) begin
                    state_d = SCHED_IDLE;
                end else begin
                    rd_en   = 1'b1;
                    idx_d   = idx_q + IDX_ONE;
                    left_d  = left_q - CNT_ONE;
                    hcnt_d  = h_q - HOLD_ONE;
                    state_d = SCHED_HOLD;
                end
            end
            SCHED_HOLD: begin
                if (abort_run) begin
                    state_d = SCHED_IDLE;
                end else if (hcnt_q != '0) begin
                    hcnt_d = hcnt_q - HOLD_ONE;
                end else if (left_q != '0) begin
                    // Prefetch in the last hold cycle keeps entries gap-free.
                    rd_en  = 1'b1;
                    idx_d  = idx_q + IDX_ONE;
                    left_d = left_q - CNT_ONE;
                    hcnt_d = h_q - HOLD_ONE;
                end else begin
                    state_d = SCHED_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = SCHED_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= SCHED_IDLE;
            idx_q      <= '0;
            left_q     <= '0;
            h_q        <= '0;
            hcnt_q     <= '0;
            strobe_q   <= 1'b0;
            done_q     <= 1'b0;
            sel_live_q <= 1'b0;
            cfg_idx_q  <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            left_q   <= left_d;
            h_q      <= h_d;
            hcnt_q   <= hcnt_d;
            strobe_q <= rd_en;
            done_q   <= done_d;
            if (rd_en) begin
                cfg_idx_q  <= idx_q;
                sel_live_q <= 1'b1;
            end else if (abort_run && (state_q != SCHED_IDLE)) begin
                sel_live_q <= 1'b0;
            end
        end
    end

`ifdef BENES_CFG_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         parity_err_q <= 1'b0;
        else if (par_abort) parity_err_q <= 1'b1;
    end
`endif

    // Selects read straight-through until a config has been fetched.
    always_comb begin
        for (int s = 0; s < STAGE_NUM; s++) begin
            o_module_select[s] = sel_live_q ? cfg_rd.module_sel[s] : '0;
            o_slot_select[s]   = sel_live_q ? cfg_rd.slot_sel[s]   : '0;
        end
    end

    assign o_cfg_valid  = (state_q == SCHED_HOLD);
    assign o_busy       = (state_q != SCHED_IDLE);
    assign o_cfg_strobe = strobe_q;
    assign o_cfg_idx    = cfg_idx_q;
    assign o_done       = done_q;

endmodule

// File: tb/tb_benes_route_sched.sv
// Self-checking bench for benes_route_sched: directed and random runs checked
// against a cycle-offset reference model of the run timeline.
module tb_benes_route_sched;
  import fhe_alu_pkg::*;

  localparam int DEPTH = CFG_DEPTH_DEF;
  localparam int AW    = CFG_AW;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  i_cfg_we = 1'b0;
  logic [AW-1:0]         i_cfg_waddr = '0;
  benes_cfg_t            i_cfg_wdata = '0;
  logic                  i_start = 1'b0;
  logic [AW-1:0]         i_base = '0;
  logic [AW:0]           i_cnt = '0;
  logic [7:0]            i_hold = '0;
  logic                  i_abort = 1'b0;
  logic [SWITCH_NUM-1:0] module_select [0:STAGE_NUM-1];
  logic [SWITCH_NUM-1:0] slot_select   [0:STAGE_NUM-1];
  logic                  cfg_valid, cfg_strobe, busy, done;
  logic [AW-1:0]         cfg_idx;
`ifdef BENES_CFG_PARITY_EN
  logic                  parity_err;
`endif

  benes_cfg_t ref_mem [DEPTH];
  benes_cfg_t last_sel = '0;
  int total = 0;
  int bad = 0;
  int step = 0;

  always #5 clk = ~clk;

  benes_route_sched #(.CFG_DEPTH(DEPTH), .HOLD_W(8)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_cfg_we        (i_cfg_we),
    .i_cfg_waddr     (i_cfg_waddr),
    .i_cfg_wdata     (i_cfg_wdata),
    .i_start         (i_start),
    .i_base          (i_base),
    .i_cnt           (i_cnt),
    .i_hold          (i_hold),
    .i_abort         (i_abort),
    .o_module_select (module_select),
    .o_slot_select   (slot_select),
    .o_cfg_valid     (cfg_valid),
    .o_cfg_strobe    (cfg_strobe),
    .o_cfg_idx       (cfg_idx),
    .o_busy          (busy),
    .o_done          (done)
`ifdef BENES_CFG_PARITY_EN
    ,
    .o_parity_err    (parity_err)
`endif
  );

  initial begin
    #500000;
    $display("FAIL watchdog step=%0d got=timeout expected=finish", step);
    $fatal(1, "watchdog expired");
  end

  function automatic benes_cfg_t observed_sel();
    benes_cfg_t c;
    for (int s = 0; s < STAGE_NUM; s++) begin
      c.module_sel[s] = module_select[s];
      c.slot_sel[s]   = slot_select[s];
    end
    return c;
  endfunction

  function automatic benes_cfg_t rand_cfg();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[CFG_W-1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input benes_cfg_t d);
    i_cfg_we    = 1'b1;
    i_cfg_waddr = a[AW-1:0];
    i_cfg_wdata = d;
    tick();
    i_cfg_we = 1'b0;
    ref_mem[a] = d;
  endtask

  // Start a run in the current cycle (T) and check cycles T+1 .. end.
  // ab_j: cycle offset at which an abort occurs (0 = none); par_ab: that abort
  // comes from a parity error rather than i_abort. st_j: stray start offset.
  // wr_j/wr_a/wr_d: config write injected at that offset.
  task automatic run(input int base, input int cnt, input int hold,
                     input int ab_j, input bit par_ab, input int st_j,
                     input int wr_j, input int wr_a, input benes_cfg_t wr_d);
    int h;
    int span;
    int last;
    int k;
    int cur_idx;
    bit aborted, e_busy, e_valid, e_strobe, e_done;
    benes_cfg_t cur_sel;
    benes_cfg_t obs_sel;
    benes_cfg_t snap [DEPTH];
    h    = (hold == 0) ? 1 : hold;
    span = cnt * h;
    last = (ab_j > 0) ? ab_j + 2 : span + 2;
    snap = ref_mem;
    cur_sel = last_sel;
    cur_idx = 0;
    i_start = 1'b1;
    i_base  = base[AW-1:0];
    i_cnt   = cnt[AW:0];
    i_hold  = hold[7:0];
    for (int j = 1; j <= last; j++) begin
      tick();
      step++;
      i_start  = 1'b0;
      i_abort  = 1'b0;
      i_cfg_we = 1'b0;
      aborted  = (ab_j > 0) && (j > ab_j);
      e_busy   = !aborted && (j <= span + 1);
      e_valid  = !aborted && (j >= 2) && (j <= span + 1);
      e_strobe = e_valid && (((j - 2) % h) == 0);
      e_done   = !aborted && (j == span + 2);
      if (aborted) begin
        cur_sel = '0;
      end else if (j >= 2) begin
        k = (j - 2) / h;
        if (k > cnt - 1) k = cnt - 1;
        cur_idx = (base + k) % DEPTH;
        cur_sel = snap[cur_idx];
      end
      obs_sel = observed_sel();
      total++;
      if (busy !== e_busy) begin
        bad++;
        $error("FAIL busy step=%0d got=%0h expected=%0h", step, busy, e_busy);
      end
      total++;
      if (cfg_valid !== e_valid) begin
        bad++;
        $error("FAIL valid step=%0d got=%0h expected=%0h", step, cfg_valid, e_valid);
      end
      total++;
      if (cfg_strobe !== e_strobe) begin
        bad++;
        $error("FAIL strobe step=%0d got=%0h expected=%0h", step, cfg_strobe, e_strobe);
      end
      total++;
      if (done !== e_done) begin
        bad++;
        $error("FAIL done step=%0d got=%0h expected=%0h", step, done, e_done);
      end
      total++;
      if (obs_sel !== cur_sel) begin
        bad++;
        $error("FAIL sel step=%0d got=%0h expected=%0h", step, obs_sel, cur_sel);
      end
      if (e_strobe || e_done) begin
        total++;
        if (cfg_idx !== cur_idx[AW-1:0]) begin
          bad++;
          $error("FAIL idx step=%0d got=%0h expected=%0h", step, cfg_idx, cur_idx[AW-1:0]);
        end
      end
`ifdef BENES_CFG_PARITY_EN
      total++;
      if (parity_err !== (par_ab && aborted)) begin
        bad++;
        $error("FAIL parity_err step=%0d got=%0h expected=%0h", step, parity_err,
               (par_ab && aborted));
      end
`endif
      if (j == ab_j && !par_ab) i_abort = 1'b1;
      if (j == st_j) begin
        i_start = 1'b1;
        i_base  = AW'(base + 7);
        i_cnt   = 3;
        i_hold  = 1;
      end
      if (j == wr_j) begin
        i_cfg_we    = 1'b1;
        i_cfg_waddr = wr_a[AW-1:0];
        i_cfg_wdata = wr_d;
        ref_mem[wr_a] = wr_d;
      end
    end
    last_sel = cur_sel;
  endtask

  initial begin
    benes_cfg_t nd;
    benes_cfg_t os;
    int rb, rc, rh;
    // Reset state
    tick();
    tick();
    os = observed_sel();
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $error("FAIL rst_busy step=%0d got=%0h expected=0", step, busy);
    end
    total++;
    if (cfg_valid !== 1'b0) begin
      bad++;
      $error("FAIL rst_valid step=%0d got=%0h expected=0", step, cfg_valid);
    end
    total++;
    if (cfg_strobe !== 1'b0) begin
      bad++;
      $error("FAIL rst_strobe step=%0d got=%0h expected=0", step, cfg_strobe);
    end
    total++;
    if (done !== 1'b0) begin
      bad++;
      $error("FAIL rst_done step=%0d got=%0h expected=0", step, done);
    end
    total++;
    if (cfg_idx !== '0) begin
      bad++;
      $error("FAIL rst_idx step=%0d got=%0h expected=0", step, cfg_idx);
    end
    total++;
    if (os !== benes_cfg_t'('0)) begin
      bad++;
      $error("FAIL rst_sel step=%0d got=%0h expected=0", step, os);
    end
    rst_n = 1'b1;
    tick();

    for (int a = 0; a < DEPTH; a++) wr(a, rand_cfg());

    // Basic run, then H=1 wrap run started in the completion cycle
    run(0, 4, 3, 0, 1'b0, 0, 0, 0, '0);
    run(14, 4, 0, 0, 1'b0, 0, 0, 0, '0);

    // Zero-count start in IDLE is ignored
    i_start = 1'b1;
    i_cnt   = '0;
    i_base  = 4'd5;
    i_hold  = 8'd1;
    for (int j = 0; j < 3; j++) begin
      tick();
      step++;
      i_start = 1'b0;
      os = observed_sel();
      total++;
      if (busy !== 1'b0) begin
        bad++;
        $error("FAIL cnt0_busy step=%0d got=%0h expected=0", step, busy);
      end
      total++;
      if (done !== 1'b0) begin
        bad++;
        $error("FAIL cnt0_done step=%0d got=%0h expected=0", step, done);
      end
      total++;
      if (os !== last_sel) begin
        bad++;
        $error("FAIL cnt0_sel step=%0d got=%0h expected=%0h", step, os, last_sel);
      end
    end

    // Abort two cycles after start, then immediate restart
    run(6, 4, 5, 2, 1'b0, 0, 0, 0, '0);
    run(9, 3, 2, 0, 1'b0, 0, 0, 0, '0);

    // Abort in IDLE has no effect on held selects
    i_abort = 1'b1;
    tick();
    step++;
    i_abort = 1'b0;
    os = observed_sel();
    total++;
    if (os !== last_sel) begin
      bad++;
      $error("FAIL idle_abort_sel step=%0d got=%0h expected=%0h", step, os, last_sel);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $error("FAIL idle_abort_busy step=%0d got=%0h expected=0", step, busy);
    end

    // Stray start during a run is ignored
    run(3, 5, 2, 0, 1'b0, 4, 0, 0, '0);

    // Overwrite entry 2 in its read cycle: old data now, new data on rerun
    nd = ~ref_mem[2];
    run(0, 4, 2, 0, 1'b0, 0, 5, 2, nd);
    run(0, 4, 2, 0, 1'b0, 0, 0, 0, '0);

    // Random runs
    for (int n = 0; n < 6; n++) begin
      rb = $urandom_range(DEPTH - 1, 0);
      rc = $urandom_range(DEPTH, 1);
      rh = $urandom_range(4, 0);
      run(rb, rc, rh, 0, 1'b0, 0, 0, 0, '0);
    end

    // Asynchronous reset mid-run; RAM contents survive
    i_start = 1'b1;
    i_base  = 4'd0;
    i_cnt   = 5'd4;
    i_hold  = 8'd2;
    tick();
    i_start = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    step++;
    os = observed_sel();
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $error("FAIL mrst_busy step=%0d got=%0h expected=0", step, busy);
    end
    total++;
    if (cfg_valid !== 1'b0) begin
      bad++;
      $error("FAIL mrst_valid step=%0d got=%0h expected=0", step, cfg_valid);
    end
    total++;
    if (cfg_strobe !== 1'b0) begin
      bad++;
      $error("FAIL mrst_strobe step=%0d got=%0h expected=0", step, cfg_strobe);
    end
    total++;
    if (cfg_idx !== '0) begin
      bad++;
      $error("FAIL mrst_idx step=%0d got=%0h expected=0", step, cfg_idx);
    end
    total++;
    if (os !== benes_cfg_t'('0)) begin
      bad++;
      $error("FAIL mrst_sel step=%0d got=%0h expected=0", step, os);
    end
    tick();
    rst_n = 1'b1;
    last_sel = '0;
    tick();
    run(1, 3, 1, 0, 1'b0, 0, 0, 0, '0);

`ifdef BENES_CFG_PARITY_EN
    // Corrupt entry 1's stored parity; run aborts when it is applied
    dut.u_ram.par_mem[1] = ~dut.u_ram.par_mem[1];
    run(0, 3, 2, 4, 1'b1, 0, 0, 0, '0);
    tick();
    step++;
    total++;
    if (parity_err !== 1'b1) begin
      bad++;
      $error("FAIL par_sticky step=%0d got=%0h expected=1", step, parity_err);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $error("FAIL par_idle step=%0d got=%0h expected=0", step, busy);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
